// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register feeding the ALU, with forwarding and load-use interlock.
// Optional: define ID_EX_FORWARDING_EN for EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [4:0]      aluc_i,
  input  logic            a_sel_pc_i,
  input  logic            b_sel_imm_i,
  input  logic            reg_write_i,
  input  logic            flush_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_wr_i,
  input  logic            exmem_load_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_wr_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] A_o,
  output logic [XLEN-1:0] B_o,
  output logic [4:0]      aluc_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic            reg_write_o,
  output logic [XLEN-1:0] pc_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [4:0]      aluc;
    logic            a_sel_pc;
    logic            b_sel_imm;
    logic            reg_write;
  } id_ex_t;

  id_ex_t          q;
  logic            valid_q;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] nxt1;
  logic [XLEN-1:0] nxt2;
  logic            nz1;
  logic            nz2;
  logic            use1;
  logic            m1_ex;
  logic            m2_ex;
  logic            m1_wb;
  logic            m2_wb;
  logic            hazard;
  logic            accept;
  logic            advance;

  assign nz1   = |q.rs1_addr;
  assign nz2   = |q.rs2_addr;
  assign use1  = ~q.a_sel_pc;
  assign m1_ex = exmem_wr_i & (exmem_rd_i == q.rs1_addr) & nz1;
  assign m2_ex = exmem_wr_i & (exmem_rd_i == q.rs2_addr) & nz2;
  assign m1_wb = memwb_wr_i & (memwb_rd_i == q.rs1_addr) & nz1;
  assign m2_wb = memwb_wr_i & (memwb_rd_i == q.rs2_addr) & nz2;

`ifdef ID_EX_FORWARDING_EN
  // A load in EX/MEM has no data yet, so it must not forward.
  always_comb begin
    op1 = q.rs1;
    if (!nz1)                     op1 = '0;
    else if (m1_ex & ~exmem_load_i) op1 = exmem_data_i;
    else if (m1_wb)               op1 = memwb_data_i;
  end

  always_comb begin
    op2 = q.rs2;
    if (!nz2)                     op2 = '0;
    else if (m2_ex & ~exmem_load_i) op2 = exmem_data_i;
    else if (m2_wb)               op2 = memwb_data_i;
  end

  assign hazard = valid_q & exmem_load_i & ((use1 & m1_ex) | m2_ex);
  assign nxt1   = op1;
  assign nxt2   = op2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_load_i, exmem_data_i, memwb_data_i};

  assign op1    = nz1 ? q.rs1 : '0;
  assign op2    = nz2 ? q.rs2 : '0;
  assign hazard = valid_q &
                  ((use1 & (m1_ex | m1_wb)) | m2_ex | m2_wb);
  // Decode keeps its read ports pointed at our sources while stalled.
  assign nxt1   = rs1_data_i;
  assign nxt2   = rs2_data_i;
`endif

  assign valid_o = valid_q & ~hazard;
  assign ready_o = ~rst_i & (~valid_q | (ready_i & valid_o));
  assign accept  = valid_i & ready_o & ~flush_i;
  assign advance = valid_o & ready_i;

  assign A_o          = q.a_sel_pc ? q.pc : op1;
  assign B_o          = q.b_sel_imm ? q.imm : op2;
  assign store_data_o = op2;
  assign aluc_o       = q.aluc;
  assign rd_addr_o    = q.rd_addr;
  assign reg_write_o  = q.reg_write;
  assign pc_o         = q.pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      q.pc        <= pc_i;
      q.rs1       <= rs1_data_i;
      q.rs2       <= rs2_data_i;
      q.imm       <= imm_i;
      q.rs1_addr  <= rs1_addr_i;
      q.rs2_addr  <= rs2_addr_i;
      q.rd_addr   <= rd_addr_i;
      q.aluc      <= aluc_i;
      q.a_sel_pc  <= a_sel_pc_i;
      q.b_sel_imm <= b_sel_imm_i;
      q.reg_write <= reg_write_i;
    end else if (advance) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Capture values retiring during the stall before they leave.
      q.rs1 <= nxt1;
      q.rs2 <= nxt2;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
// Expectations adapt to whether ID_EX_FORWARDING_EN is defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, flush_i, ready_i, valid_o;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, aluc_i;
  logic        a_sel_pc_i, b_sel_imm_i, reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_wr_i, exmem_load_i, memwb_wr_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] A_o, B_o, store_data_o, pc_o;
  logic [4:0]  aluc_o, rd_addr_o;
  logic        reg_write_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .aluc_i(aluc_i),
    .a_sel_pc_i(a_sel_pc_i), .b_sel_imm_i(b_sel_imm_i),
    .reg_write_i(reg_write_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_wr_i(exmem_wr_i),
    .exmem_load_i(exmem_load_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_wr_i(memwb_wr_i),
    .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .A_o(A_o), .B_o(B_o), .aluc_o(aluc_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .pc_o(pc_o)
  );

  typedef struct {
    logic        v, rdy, fl;
    logic [4:0]  a1, a2, rd, aluc;
    logic [31:0] d1, d2, imm, pc;
    logic        asel, bsel, rw;
    logic [4:0]  exrd, wbrd;
    logic        exwr, exld, wbwr;
    logic [31:0] exd, wbd;
    logic        ck, ev, er;
    logic [31:0] ea, eb, es, epc;
    logic [4:0]  ealuc, erd;
    logic        erw;
  } vec_t;

  vec_t t[$];
  vec_t x;

  function automatic vec_t idle();
    vec_t r;
    r = '{default: '0};
    r.rdy = 1'b1;
    r.er  = 1'b1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_i = v.v; ready_i = v.rdy; flush_i = v.fl;
    rs1_addr_i = v.a1; rs2_addr_i = v.a2; rd_addr_i = v.rd;
    rs1_data_i = v.d1; rs2_data_i = v.d2; imm_i = v.imm; pc_i = v.pc;
    aluc_i = v.aluc; a_sel_pc_i = v.asel; b_sel_imm_i = v.bsel;
    reg_write_i = v.rw;
    exmem_rd_i = v.exrd; exmem_wr_i = v.exwr; exmem_load_i = v.exld;
    exmem_data_i = v.exd;
    memwb_rd_i = v.wbrd; memwb_wr_i = v.wbwr; memwb_data_i = v.wbd;
  endtask

  initial begin
    // single op
    x = idle(); x.v = 1; x.a1 = 1; x.d1 = 5; x.a2 = 2; x.d2 = 3;
    x.aluc = 5'b00001; x.rd = 9; x.rw = 1; x.pc = 32'h40; t.push_back(x);
    x = idle(); x.ck = 1; x.ev = 1; x.ea = 5; x.eb = 3; x.es = 3;
    x.ealuc = 1; x.erd = 9; x.erw = 1; x.epc = 32'h40; t.push_back(x);
    x = idle(); t.push_back(x);
    // EX/MEM priority over MEM/WB
    x = idle(); x.v = 1; x.a1 = 7; x.d1 = 1; x.aluc = 2; x.rdy = 0;
    t.push_back(x);
    x = idle(); x.rdy = 0; x.d1 = 1; x.exwr = 1; x.exrd = 7;
    x.exd = 32'h40; x.wbwr = 1; x.wbrd = 7; x.wbd = 32'h99;
    x.ev = FWD; x.er = 0; x.ck = FWD; x.ea = 32'h40; x.ealuc = 2;
    t.push_back(x);
    x = idle(); x.d1 = 1; x.ck = 1; x.ev = 1;
    x.ea = FWD ? 32'h40 : 32'h1; x.ealuc = 2; t.push_back(x);
    x = idle(); t.push_back(x);
    // load-use
    x = idle(); x.v = 1; x.a2 = 4; x.d2 = 7; x.aluc = 3; t.push_back(x);
    x = idle(); x.d2 = 7; x.exwr = 1; x.exld = 1; x.exrd = 4;
    x.exd = 32'hdead; x.er = 0; t.push_back(x);
    t.push_back(x);
    x = idle(); x.rdy = 0; x.d2 = 32'h1234; x.wbwr = 1; x.wbrd = 4;
    x.wbd = 32'h1234; x.ev = FWD; x.er = 0; x.ck = FWD;
    x.eb = 32'h1234; x.es = 32'h1234; x.ealuc = 3; t.push_back(x);
    x = idle(); x.d2 = 32'h1234; x.ck = 1; x.ev = 1;
    x.eb = 32'h1234; x.es = 32'h1234; x.ealuc = 3; t.push_back(x);
    x = idle(); t.push_back(x);
    // back-pressure refresh
    x = idle(); x.v = 1; x.a1 = 2; x.d1 = 32'h11; x.aluc = 4; x.rdy = 0;
    t.push_back(x);
    x = idle(); x.rdy = 0; x.d1 = 32'hAA; x.wbwr = 1; x.wbrd = 2;
    x.wbd = 32'hAA; x.ev = FWD; x.er = 0; x.ck = FWD; x.ea = 32'hAA;
    x.ealuc = 4; t.push_back(x);
    x = idle(); x.rdy = 0; x.d1 = FWD ? 32'h11 : 32'hAA; x.ck = 1;
    x.ev = 1; x.er = 0; x.ea = 32'hAA; x.ealuc = 4; t.push_back(x);
    t.push_back(x);
    x = idle(); x.d1 = FWD ? 32'h11 : 32'hAA; x.ck = 1; x.ev = 1;
    x.ea = 32'hAA; x.ealuc = 4; t.push_back(x);
    x = idle(); t.push_back(x);
    // x0 source
    x = idle(); x.v = 1; x.imm = 32'h10; x.bsel = 1; x.aluc = 5;
    x.rdy = 0; t.push_back(x);
    x = idle(); x.exwr = 1; x.exld = 1; x.exrd = 0; x.exd = 32'hFFFF;
    x.ck = 1; x.ev = 1; x.eb = 32'h10; x.ealuc = 5; t.push_back(x);
    x = idle(); t.push_back(x);
    // PC operand, unused rs1 never interlocks
    x = idle(); x.v = 1; x.asel = 1; x.pc = 32'h100; x.a1 = 3;
    x.d1 = 32'h33; x.imm = 8; x.bsel = 1; x.aluc = 6; x.rd = 5;
    x.rw = 1; t.push_back(x);
    x = idle(); x.exwr = 1; x.exld = 1; x.exrd = 3; x.exd = 32'hbad;
    x.ck = 1; x.ev = 1; x.ea = 32'h100; x.eb = 8; x.ealuc = 6;
    x.erd = 5; x.erw = 1; x.epc = 32'h100; t.push_back(x);
    x = idle(); t.push_back(x);
    // flush drops a coincident accept
    x = idle(); x.v = 1; x.a1 = 1; x.d1 = 32'h55; x.aluc = 7;
    t.push_back(x);
    x = idle(); x.v = 1; x.fl = 1; x.a1 = 1; x.d1 = 32'h66; x.aluc = 9;
    x.rd = 3; x.rw = 1; x.ck = 1; x.ev = 1; x.ea = 32'h55;
    x.ealuc = 7; t.push_back(x);
    x = idle(); t.push_back(x);
    t.push_back(x);
    // flush while stalled
    x = idle(); x.v = 1; x.a1 = 1; x.d1 = 32'h22; x.aluc = 10;
    x.rdy = 0; t.push_back(x);
    x = idle(); x.rdy = 0; x.fl = 1; x.ck = 1; x.ev = 1; x.er = 0;
    x.ea = 32'h22; x.ealuc = 10; t.push_back(x);
    x = idle(); t.push_back(x);

    // reset
    x = idle(); x.rdy = 0;
    drive(x);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", {31'b0, valid_o}, 0);
    check("rst_ready_o", {31'b0, ready_o}, 0);
    check("rst_A_o", A_o, 0);
    check("rst_B_o", B_o, 0);
    check("rst_aluc_o", {27'b0, aluc_o}, 0);
    check("rst_store", store_data_o, 0);
    check("rst_rd_addr", {27'b0, rd_addr_o}, 0);
    check("rst_reg_write", {31'b0, reg_write_o}, 0);
    check("rst_pc_o", pc_o, 0);
    rst = 1'b0;

    for (int i = 0; i < t.size(); i++) begin
      @(posedge clk);
      #1;
      drive(t[i]);
      #2;
      check($sformatf("v%0d_valid_o", i), {31'b0, valid_o},
            {31'b0, t[i].ev});
      check($sformatf("v%0d_ready_o", i), {31'b0, ready_o},
            {31'b0, t[i].er});
      if (t[i].ck) begin
        check($sformatf("v%0d_A_o", i), A_o, t[i].ea);
        check($sformatf("v%0d_B_o", i), B_o, t[i].eb);
        check($sformatf("v%0d_store", i), store_data_o, t[i].es);
        check($sformatf("v%0d_aluc_o", i), {27'b0, aluc_o},
              {27'b0, t[i].ealuc});
        check($sformatf("v%0d_rd_addr", i), {27'b0, rd_addr_o},
              {27'b0, t[i].erd});
        check($sformatf("v%0d_reg_write", i), {31'b0, reg_write_o},
              {31'b0, t[i].erw});
        check($sformatf("v%0d_pc_o", i), pc_o, t[i].epc);
      end
    end

    // reset while stalled discards the held instruction
    @(posedge clk);
    #1;
    x = idle(); x.v = 1; x.a1 = 1; x.d1 = 32'h77; x.aluc = 8; x.rdy = 0;
    drive(x);
    @(posedge clk);
    #1;
    x = idle(); x.rdy = 0;
    drive(x);
    #2;
    check("mid_held_valid", {31'b0, valid_o}, 1);
    check("mid_held_aluc", {27'b0, aluc_o}, 8);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("mid_rst_valid", {31'b0, valid_o}, 0);
    check("mid_rst_ready", {31'b0, ready_o}, 1);
    check("mid_rst_aluc", {27'b0, aluc_o}, 0);
    check("mid_rst_A", A_o, 0);
    @(posedge clk);
    #3;
    check("mid_rst_valid2", {31'b0, valid_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Captures decoded operands and control, applies operand forwarding from the EX/MEM and MEM/WB stages, and drives the ALU inputs.
  - ALU operand A, operand B and 5-bit ALU control come from this block.
- Valid/ready handshake on both sides; supports pipeline stall, flush and load-use interlock.

Parameters:
- XLEN, 32, datapath width in bits.
- RA_W, 5, register-address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  decode presents an instruction.
- ready_o  output  1  stage can accept this cycle.
- pc_i  input  XLEN  instruction PC.
- rs1_data_i  input  XLEN  register-file read 1.
- rs2_data_i  input  XLEN  register-file read 2.
- imm_i  input  XLEN  sign-extended immediate.
- rs1_addr_i  input  RA_W  source 1 index.
- rs2_addr_i  input  RA_W  source 2 index.
- rd_addr_i  input  RA_W  destination index.
- aluc_i  input  5  ALU operation code, passed through unchanged.
- a_sel_pc_i  input  1  1: operand A = PC; 0: operand A = rs1.
- b_sel_imm_i  input  1  1: operand B = imm; 0: operand B = rs2.
- reg_write_i  input  1  instruction writes rd.
- flush_i  input  1  kill the held instruction and any incoming one.
- exmem_rd_i  input  RA_W  EX/MEM destination.
- exmem_wr_i  input  1  EX/MEM writes rd.
- exmem_load_i  input  1  EX/MEM is a load (data not yet valid).
- exmem_data_i  input  XLEN  EX/MEM ALU result.
- memwb_rd_i  input  RA_W  MEM/WB destination.
- memwb_wr_i  input  1  MEM/WB writes rd.
- memwb_data_i  input  XLEN  MEM/WB writeback data.
- valid_o  output  1  ALU inputs valid.
- ready_i  input  1  execute stage consumes this cycle.
- A_o  output  XLEN  ALU operand A.
- B_o  output  XLEN  ALU operand B.
- aluc_o  output  5  ALU control.
- store_data_o  output  XLEN  forwarded rs2, for stores.
- rd_addr_o  output  RA_W  destination.
- reg_write_o  output  1  write enable.
- pc_o  output  XLEN  PC.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All registered state and all outputs go to 0; valid_q=0.
  - Reset mid-stall discards the held instruction.
- Held registers: valid_q, pc, rs1/rs2 value, imm, addresses, aluc, selects, reg_write.
- Accept: valid_i & ready_o & ~flush_i loads all fields; valid_q=1 next cycle. Latency is 1 cycle from accept to valid_o.
- Forwarding:
  - Operand value for rsN = exmem_data_i if exmem_wr_i & exmem_rd_i==rsN & rsN!=0 & ~exmem_load_i.
  - Else memwb_data_i if memwb_wr_i & memwb_rd_i==rsN & rsN!=0.
  - Else the held register value. EX/MEM has priority over MEM/WB.
  - Source x0 is never forwarded and always reads 0.
- Refresh: every cycle valid_q=1 and the stage is not advancing, the forwarded rs1/rs2 values are written back into the held registers. This keeps results that retire during a stall.
- Load-use hazard: hazard = valid_q & exmem_load_i & exmem_wr_i & exmem_rd_i!=0 & (exmem_rd_i==rs1 used, or exmem_rd_i==rs2 used).
  - rs1 is used when a_sel_pc=0.
  - rs2 is always used (store data).
- valid_o = valid_q & ~hazard.
- A_o = pc or forwarded rs1; B_o = imm or forwarded rs2; store_data_o = forwarded rs2.
- ready_o = ~valid_q | (ready_i & valid_o). This is combinational through ready_i.
- Advance when valid_o & ready_i. If no new accept occurs in the same cycle, valid_q←0.
- Flush:
  - valid_q←0 next cycle and any same-cycle valid_i is dropped.
  - Flush has priority over accept and advance.
  - Data registers may keep stale values.
- Outputs other than valid_o may change while valid_o=0; downstream ignores them.
- While valid_o=1 & ready_i=0, the control outputs are stable. Operand outputs change only by forwarding-refresh of the same architectural value.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN.
- Defined: forwarding and refresh operate as above.
- Undefined:
  - No forwarding muxes; operands come from the held registers only.
  - hazard additionally asserts on any rs1/rs2 match, x0 excluded, with an EX/MEM or MEM/WB writer. The load flag is ignored.
  - The held operand is reloaded from rs1_data_i/rs2_data_i every stalled cycle. Decode holds its read addresses stable while ready_o=0.

Test Plan:
- Reset then single op:
  - Stimulus: rs1=5, rs2=3, aluc=00001, valid_i for 1 cycle, ready_i=1.
  - Required: valid_o=1 exactly one cycle later with A_o=5, B_o=3, aluc_o=00001. All outputs are 0 during reset.
- EX/MEM forward:
  - Stimulus: held rs1=x7 (reg value 1); exmem_wr=1, exmem_rd=7, exmem_data=0x40; memwb also targets x7 with 0x99.
  - Required: A_o=0x40 (EX/MEM priority).
- Load-use interlock:
  - Stimulus: exmem_load=1, exmem_rd=rs2=x4 for 2 cycles, then memwb_rd=4 with data 0x1234.
  - Required: valid_o=0 for 2 cycles, then valid_o=1 with B_o=0x1234. ready_o=0 throughout the stall.
- Back-pressure refresh:
  - Stimulus: ready_i=0 for 3 cycles while memwb writes x2=0xAA for one cycle only; held rs1=x2.
  - Required: A_o=0xAA persists after the write-back leaves.
- Flush:
  - Stimulus: valid_q=1, flush_i=1 coincident with valid_i=1.
  - Required: next cycle valid_o=0, and the incoming instruction never appears.
- x0 source:
  - Stimulus: rs1=x0, exmem_wr=1, exmem_rd=0, exmem_data=0xFFFF.
  - Required: A_o=0, no hazard.
